// File: rtl/sprite_blitter.sv
// sprite_blitter: XOR-draws a sprite into a packed 1bpp framebuffer
// (16 pixels per word, MSB = leftmost). Each sprite row is one read-modify-write
// of the left word and, if the shifted pattern spills over, one of the right
// word. Clipped at the right/bottom edges; collision reports any 1->0 pixel flip.
// Optional feature macro: SCHIP_SPRITE16_EN (rows=0 selects a 16-row sprite,
// 16 pixels wide in hires, fetched as two bytes per row).
//
// Handshake: start is accepted only while idle (busy=0, done=0). The request
// inputs are captured on that edge. busy is high while the operation runs.
// done pulses for one cycle as busy drops. collision is stable from done until
// the next accepted start.
module sprite_blitter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hires,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic [3:0]  rows,
    output logic [4:0]  sprAddr,
    input  logic [7:0]  sprData,
    output logic [8:0]  fbAddr,
    input  logic [15:0] fbRdata,
    output logic [15:0] fbWdata,
    output logic        fbWe,
    output logic        busy,
    output logic        done,
    output logic        collision
);

    typedef enum logic [2:0] {IDLE, FETCH, RDL, WRL, RDR, WRR, DONE} state_t;

    state_t      state, stateNext;
    logic        hiresR, wideR, halfR;
    logic [6:0]  colR;
    logic [5:0]  rowY;
    logic [3:0]  rowIdx;
    logic [4:0]  rowsLeft;
    logic [7:0]  byteHi, byteLo;
    logic        collisionR;

    logic [4:0]  effRows;
    logic        startWide;
    logic [8:0]  lineBase, wordL, wordR;
    logic        lastWord, needRight, lastRow, rowAdvance;
    logic [15:0] spr16, maskL, maskR;
    logic [31:0] pattern;
    logic [6:0]  nextY;

    // Effective row count and sprite width chosen at start.
    always_comb begin
`ifdef SCHIP_SPRITE16_EN
        effRows   = (rows == 4'd0) ? 5'd16 : {1'b0, rows};
        startWide = hires && (rows == 4'd0);
`else
        effRows   = {1'b0, rows};
        startWide = 1'b0;
`endif
    end

    // Word addressing, mask generation and end-of-draw detection.
    assign lineBase   = hiresR ? {rowY, 3'b000} : {1'b0, rowY, 2'b00};
    assign wordL      = lineBase + {6'd0, colR[6:4]};
    assign wordR      = wordL + 9'd1;
    assign lastWord   = hiresR ? (colR[6:4] == 3'd7) : (colR[5:4] == 2'd3);
    assign spr16      = wideR ? {byteHi, byteLo} : {byteLo, 8'h00};
    assign pattern    = {spr16, 16'h0000} >> colR[3:0];
    assign maskL      = pattern[31:16];
    assign maskR      = pattern[15:0];
    assign needRight  = (maskR != 16'h0000) && !lastWord;
    assign nextY      = {1'b0, rowY} + 7'd1;
    assign lastRow    = (rowsLeft == 5'd1) || (nextY >= (hiresR ? 7'd64 : 7'd32));
    assign rowAdvance = ((state == WRL) && !needRight) || (state == WRR);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state and memory-port outputs.
    always_comb begin
        stateNext = state;
        sprAddr   = 5'd0;
        fbAddr    = 9'd0;
        fbWdata   = 16'h0000;
        fbWe      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) stateNext = (effRows == 5'd0) ? DONE : FETCH;
            end
            FETCH: begin
                busy      = 1'b1;
                sprAddr   = wideR ? {rowIdx, halfR} : {1'b0, rowIdx};
                stateNext = (wideR && !halfR) ? FETCH : RDL;
            end
            RDL: begin
                busy      = 1'b1;
                fbAddr    = wordL;
                stateNext = WRL;
            end
            WRL: begin
                busy    = 1'b1;
                fbAddr  = wordL;
                fbWe    = 1'b1;
                fbWdata = fbRdata ^ maskL;
                if (needRight)    stateNext = RDR;
                else if (lastRow) stateNext = DONE;
                else              stateNext = FETCH;
            end
            RDR: begin
                busy      = 1'b1;
                fbAddr    = wordR;
                stateNext = WRR;
            end
            WRR: begin
                busy      = 1'b1;
                fbAddr    = wordR;
                fbWe      = 1'b1;
                fbWdata   = fbRdata ^ maskR;
                stateNext = lastRow ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Request capture, sprite byte latching, row stepping and collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            hiresR     <= 1'b0;
            wideR      <= 1'b0;
            halfR      <= 1'b0;
            colR       <= 7'd0;
            rowY       <= 6'd0;
            rowIdx     <= 4'd0;
            rowsLeft   <= 5'd0;
            byteHi     <= 8'h00;
            byteLo     <= 8'h00;
            collisionR <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                hiresR     <= hires;
                wideR      <= startWide;
                halfR      <= 1'b0;
                colR       <= hires ? x : {1'b0, x[5:0]};
                rowY       <= hires ? y : {1'b0, y[4:0]};
                rowIdx     <= 4'd0;
                rowsLeft   <= effRows;
                collisionR <= 1'b0;
            end
            if (state == FETCH && wideR) begin
                halfR <= ~halfR;
                if (halfR) byteHi <= sprData;
            end
            if (state == RDL) byteLo <= sprData;
            if (state == WRL) collisionR <= collisionR | (|(fbRdata & maskL));
            if (state == WRR) collisionR <= collisionR | (|(fbRdata & maskR));
            if (rowAdvance) begin
                rowIdx   <= rowIdx + 4'd1;
                rowY     <= nextY[5:0];
                rowsLeft <= rowsLeft - 5'd1;
            end
        end
    end

    assign collision = collisionR;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: scoreboard bench for sprite_blitter. A pixel-level model
// predicts every framebuffer write, the done latency and the collision flag;
// a monitor compares them as the DUT produces writes and done pulses.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset, start, hires;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [3:0]  rows;
  logic [4:0]  sprAddr;
  logic [7:0]  sprData;
  logic [8:0]  fbAddr;
  logic [15:0] fbRdata, fbWdata;
  logic        fbWe, busy, done, collision;

  logic [7:0]  spr_mem [32];
  logic [15:0] fb_mem  [512];
  logic [15:0] ref_fb  [512];

  logic [24:0] exp_q[$];
  logic [31:0] exp_cyc_q[$];
  logic        exp_coll_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [24:0] got_w;

  sprite_blitter dut (
    .clk(clk), .reset(reset), .start(start), .hires(hires),
    .x(x), .y(y), .rows(rows),
    .sprAddr(sprAddr), .sprData(sprData),
    .fbAddr(fbAddr), .fbRdata(fbRdata), .fbWdata(fbWdata), .fbWe(fbWe),
    .busy(busy), .done(done), .collision(collision)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous sprite ROM and framebuffer RAM (1-cycle read latency)
  always @(posedge clk) begin
    sprData <= spr_mem[sprAddr];
    fbRdata <= fb_mem[fbAddr];
    if (fbWe) fb_mem[fbAddr] = fbWdata;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fill_fb(input bit rnd);
    logic [15:0] v;
    for (int i = 0; i < 512; i++) begin
      v = rnd ? 16'($urandom) : 16'h0000;
      fb_mem[i] = v;
      ref_fb[i] = v;
    end
  endtask

  // Pixel-level reference: place each set sprite pixel at (x+c, y+r),
  // drop those outside the field, and group the flips into words.
  task automatic model_draw(input logic h, input logic [6:0] xi, input logic [5:0] yi,
                            input logic [3:0] ni, input int now);
    int wdt, hgt, wpl, px0, py0, nrows, sw, k, py, px, w0, addr;
    logic [15:0] pat, flip_l, flip_r, old;
    logic [8:0]  a9;
    logic        coll;
    wdt = h ? 128 : 64;
    hgt = h ? 64 : 32;
    wpl = h ? 8 : 4;
    px0 = int'(xi) % wdt;
    py0 = int'(yi) % hgt;
    nrows = int'(ni);
    sw = 8;
`ifdef SCHIP_SPRITE16_EN
    if (ni == 4'd0) begin
      nrows = 16;
      if (h) sw = 16;
    end
`endif
    k = 1;
    coll = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      py = py0 + r;
      if (py >= hgt) break;
      pat = (sw == 16) ? {spr_mem[2*r], spr_mem[2*r+1]} : {spr_mem[r], 8'h00};
      flip_l = 16'h0;
      flip_r = 16'h0;
      w0 = px0 / 16;
      for (int c = 0; c < sw; c++) begin
        px = px0 + c;
        if (pat[15-c] && px < wdt) begin
          if (px / 16 == w0) flip_l[15 - px % 16] = 1'b1;
          else               flip_r[15 - px % 16] = 1'b1;
        end
      end
      addr = py * wpl + w0;
      a9 = addr[8:0];
      old = ref_fb[a9];
      coll = coll | (|(old & flip_l));
      ref_fb[a9] = old ^ flip_l;
      exp_q.push_back({a9, old ^ flip_l});
      k += (sw == 16) ? 4 : 3;
      if (flip_r != 16'h0) begin
        a9 = a9 + 9'd1;
        old = ref_fb[a9];
        coll = coll | (|(old & flip_r));
        ref_fb[a9] = old ^ flip_r;
        exp_q.push_back({a9, old ^ flip_r});
        k += 2;
      end
    end
    exp_cyc_q.push_back(32'(now + k));
    exp_coll_q.push_back(coll);
  endtask

  // monitor: compare writes and done pulses against the expected queues
  always @(negedge clk) begin
    if (!reset) begin
      if (fbWe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h", fbAddr, fbWdata);
        end else begin
          got_w = exp_q.pop_front();
          check("fb_write", {7'd0, fbAddr, fbWdata}, {7'd0, got_w});
        end
      end
      if (done) begin
        if (exp_cyc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cyc=%0d", cyc);
        end else begin
          check("done_latency", cyc, exp_cyc_q.pop_front());
          check("collision", {31'd0, collision}, {31'd0, exp_coll_q.pop_front()});
          check("missing_writes", exp_q.size(), 0);
          check("busy_at_done", {31'd0, busy}, 0);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fbWe"}, {31'd0, fbWe}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_collision"}, {31'd0, collision}, 0);
    check({tag, "_fbAddr"}, {23'd0, fbAddr}, 0);
    check({tag, "_sprAddr"}, {27'd0, sprAddr}, 0);
    check({tag, "_fbWdata"}, {16'd0, fbWdata}, 0);
  endtask

  // driver: issue one draw, optionally poke start while busy, wait for done
  task automatic draw(input logic h, input logic [6:0] xi, input logic [5:0] yi,
                      input logic [3:0] ni, input bit poke_busy);
    int waited;
    @(negedge clk);
    model_draw(h, xi, yi, ni, cyc);
    hires = h; x = xi; y = yi; rows = ni; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke_busy && ni != 4'd0) begin
      check("busy_during_draw", {31'd0, busy}, 1);
      hires = ~h; x = 7'($urandom); y = 6'($urandom); rows = 4'($urandom); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waited = 0;
    while (!done && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout waited=%0d", waited);
    end
    @(negedge clk);
  endtask

  initial begin
    int seen, waited;
    reset = 1'b1; start = 1'b0; hires = 1'b0; x = 7'd0; y = 6'd0; rows = 4'd0;
    for (int i = 0; i < 32; i++) spr_mem[i] = 8'h00;
    fill_fb(0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // single row, then redraw to erase and collide
    spr_mem[0] = 8'hF0;
    draw(1'b0, 7'd0, 6'd0, 4'd1, 1'b0);
    check("erase_pre_addr0", {16'd0, fb_mem[0]}, 32'h0000F000);
    draw(1'b0, 7'd0, 6'd0, 4'd1, 1'b0);
    check("erase_post_addr0", {16'd0, fb_mem[0]}, 32'h00000000);

    // hires straddling two words
    fill_fb(0);
    spr_mem[0] = 8'hFF;
    draw(1'b1, 7'd12, 6'd1, 4'd1, 1'b0);
    check("straddle_addr8", {16'd0, fb_mem[8]}, 32'h0000000F);
    check("straddle_addr9", {16'd0, fb_mem[9]}, 32'h0000F000);

    // bottom-right corner clipping
    fill_fb(0);
    for (int i = 0; i < 4; i++) spr_mem[i] = 8'hFF;
    draw(1'b0, 7'd60, 6'd30, 4'd4, 1'b0);
    check("clip_addr123", {16'd0, fb_mem[123]}, 32'h0000000F);
    check("clip_addr127", {16'd0, fb_mem[127]}, 32'h0000000F);

    // coordinate wrap
    fill_fb(0);
    spr_mem[0] = 8'h80;
    draw(1'b0, 7'd66, 6'd33, 4'd1, 1'b0);
    check("wrap_addr4", {16'd0, fb_mem[4]}, 32'h00002000);

    // zero rows
    draw(1'b0, 7'd5, 6'd5, 4'd0, 1'b0);
    draw(1'b1, 7'd100, 6'd50, 4'd0, 1'b0);

    // reset during the second WRL of a colliding 4-row draw
    fill_fb(0);
    fb_mem[0] = 16'hFFFF;
    ref_fb[0] = 16'hFFFF;
    for (int i = 0; i < 4; i++) spr_mem[i] = 8'hFF;
    @(negedge clk);
    model_draw(1'b0, 7'd0, 6'd0, 4'd4, cyc);
    hires = 1'b0; x = 7'd0; y = 6'd0; rows = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    waited = 0;
    while (seen < 2 && waited < 100) begin
      if (fbWe) seen++;
      if (seen < 2) begin
        @(negedge clk);
        waited++;
      end
    end
    check("reset_reached_wrl", seen, 2);
    #1 reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    exp_q.delete();
    exp_cyc_q.delete();
    exp_coll_q.delete();
    reset = 1'b0;
    fill_fb(0);
    spr_mem[0] = 8'hA5;
    draw(1'b1, 7'd0, 6'd0, 4'd1, 1'b0);
    check("after_reset_addr0", {16'd0, fb_mem[0]}, 32'h0000A500);

    // randomized draws over random framebuffer contents
    for (int n = 0; n < 40; n++) begin
      if (n % 4 == 0) fill_fb(1);
      for (int i = 0; i < 32; i++)
        spr_mem[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      draw(1'($urandom), 7'($urandom), 6'($urandom), 4'($urandom_range(0, 15)),
           1'($urandom));
    end

    check("leftover_writes", exp_q.size(), 0);
    check("leftover_dones", exp_cyc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
